// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the bit-serial ALU sequencer.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_bit.sv
// Combinational 1-bit ALU slice; unsupported op codes drive y=1, cout=0.
module alu_bit
    import alu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic            a,
    input  logic            b,
    input  logic            cin,
    output logic            y,
    output logic            cout
);

    always_comb begin
        y    = 1'b1;
        cout = 1'b0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADD: begin
                y    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: steps WIDTH-bit operands LSB-first through one
// alu_bit slice, assembling the result in a right-shifting register.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_carry_out;

    logic w_y;
    logic w_cout;

    alu_bit u_alu_bit (
        .op   (r_op),
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .y    (w_y),
        .cout (w_cout)
    );

    // Sequencer: DONE accepts a new start just like IDLE for back-to-back ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_op        <= op;
                        r_cnt       <= '0;
                        r_carry     <= 1'b0;
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_result <= {w_y, r_result[WIDTH-1:1]};
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_carry  <= w_cout;
                    // The last bit is consumed while the counter holds WIDTH-1.
                    if (r_cnt == CNT_LAST) begin
                        r_carry_out <= w_cout;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl with a scoreboard of expected results.
module tb_alu_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    int n_cmp;
    int n_err;
    logic [W:0] exp_q[$];

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [2:0] m_op, input logic [W-1:0] m_a,
                                         input logic [W-1:0] m_b);
        logic [W:0] sum;
        sum = {1'b0, m_a} + {1'b0, m_b};
        case (m_op)
            3'b000:  return {1'b0, m_a & m_b};
            3'b010:  return {1'b0, m_a | m_b};
            3'b011:  return {1'b0, m_a ^ m_b};
            3'b100:  return sum;
            default: return {1'b0, {W{1'b1}}};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a start pulse across one edge and record the expected outcome.
    task automatic issue(input logic [2:0] i_op, input logic [W-1:0] i_a, input logic [W-1:0] i_b);
        start = 1'b1;
        op    = i_op;
        a     = i_a;
        b     = i_b;
        exp_q.push_back(model(i_op, i_a, i_b));
        step();
        start = 1'b0;
        op    = 3'b111;
        a     = $urandom();
        b     = $urandom();
    endtask

    // Step until done; lat = edges after the start edge, busy_bad counts busy=0 while waiting.
    task automatic wait_done(output int lat, output int busy_bad);
        lat      = 0;
        busy_bad = 0;
        while (lat < 40) begin
            if (!busy && !done) busy_bad++;
            step();
            lat++;
            if (done) break;
        end
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat);
        logic [W:0] exp;
        n_cmp++;
        if (lat !== exp_lat || !done) begin
            n_err++;
            $display("FAIL %s latency: got %0d done=%b, want %0d", name, lat, done, exp_lat);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_cmp++;
        if (result !== exp[W-1:0] || carry_out !== exp[W]) begin
            n_err++;
            $display("FAIL %s result: got %h/%b, want %h/%b", name, result, carry_out,
                     exp[W-1:0], exp[W]);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        step();
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, result, carry_out} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h c=%b, want all 0",
                     busy, done, result, carry_out);
        end
    endtask

    task automatic test_single(input string name, input logic [2:0] t_op,
                               input logic [W-1:0] t_a, input logic [W-1:0] t_b);
        int lat, bb;
        issue(t_op, t_a, t_b);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_start: got %b, want 1", name, busy);
        end
        wait_done(lat, bb);
        n_cmp++;
        if (bb != 0) begin
            n_err++;
            $display("FAIL %s busy_gap: got %0d idle cycles, want 0", name, bb);
        end
        check_result(name, lat, W);
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_pulse_width: got done=%b, want 0", name, done);
        end
    endtask

    task automatic test_xor_ignore_start();
        int lat, bb;
        issue(3'b011, 8'hAA, 8'hFF);
        step();
        step();
        start = 1'b1;
        op    = 3'b100;
        a     = 8'h12;
        b     = 8'h34;
        step();
        start = 1'b0;
        wait_done(lat, bb);
        check_result("xor_ignore_start", lat + 3, W);
    endtask

    task automatic test_back_to_back();
        int lat, bb;
        issue(3'b010, 8'h0F, 8'hF0);
        wait_done(lat, bb);
        check_result("b2b_or", lat + 1, W + 1);
        for (int i = 0; i < 5; i++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom()), W'($urandom()));
            wait_done(lat, bb);
            check_result($sformatf("b2b_rand%0d", i), lat, W);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(3'b100, 8'hFF, 8'h01);
        void'(exp_q.pop_back());
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, result, carry_out} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b result=%h c=%b, want all 0",
                     busy, done, result, carry_out);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", seen);
        end
    endtask

    task automatic test_rst_start();
        rst   = 1'b1;
        start = 1'b1;
        op    = 3'b000;
        a     = 8'hFF;
        b     = 8'hFF;
        step();
        rst   = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_start_busy: got %b, want 0", busy);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_start_idle: got busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single("and", 3'b000, 8'hF0, 8'h3C);
        test_single("add_wrap", 3'b100, 8'hFF, 8'h01);
        test_single("add", 3'b100, 8'h25, 8'h1A);
        test_single("unsupported", 3'b001, 8'h5A, 8'hC3);
        test_xor_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_rst_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
